uart_autobaud: RTL and testbench
================================

UART_AUTOBAUD -- requirements
Module: uart_autobaud

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 100, giving the main clock frequency in MHz, which SHALL be a multiple of 10.
REQ-002 The block SHALL have parameter BAUD_DIV_WIDTH, default 8, giving the width of baud_div.
REQ-003 The block SHALL have parameter DEFAULT_DIV, default 129, giving the reset value of baud_div (9600 baud).
REQ-004 The block SHALL have port clk, input, 1 bit: the main clock; one clock only.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port en, input, 1 bit: a level that arms detection.
REQ-007 The block SHALL have port rx, input, 1 bit: the asynchronous UART line, idle high.
REQ-008 The block SHALL have port baud_div, output, BAUD_DIV_WIDTH bits: the measured division, 10M/8/baudrate-1, in the same format the uart_tx/uart_rx pair consumes.
REQ-009 The block SHALL have port busy, output, 1 bit: high while armed or measuring.
REQ-010 The block SHALL have port ack, output, 1 bit: a one-cycle pulse meaning a valid measurement was captured.
REQ-011 The block SHALL have port err, output, 1 bit: a one-cycle pulse meaning the measurement was rejected.

Function
REQ-012 rx SHALL pass through a 2-flop synchronizer; a falling edge is a cycle where the synchronized value is 0 and the previous synchronized value was 1.
REQ-013 The block SHALL generate a 10 MHz tick every CLK_DIV = CLK_FREQ/10 clocks; the prescaler SHALL restart at 0 on entry to MEASURE.
REQ-014 The sync character SHALL be 0x55 (8N1, LSB first), giving falling edges at bit times 0, 2, 4, 6 and 8 after the start edge.
REQ-015 The block SHALL use states IDLE, ARMED, MEASURE and CHECK.
REQ-016 IDLE: busy=0; en=1 SHALL go to ARMED on the next cycle.
REQ-017 ARMED: busy=1; en=0 SHALL go to IDLE; a falling edge SHALL go to MEASURE with T=0 and edge_cnt=0.
REQ-018 MEASURE: T (width BAUD_DIV_WIDTH+6) SHALL increment on each tick; each falling edge SHALL increment edge_cnt.
REQ-019 MEASURE: at the falling edge where edge_cnt becomes 1, the block SHALL latch P1=T.
REQ-020 MEASURE: at the falling edge where edge_cnt becomes 4, the block SHALL go to CHECK.
REQ-021 MEASURE: if T would increment past all-ones (overflow), the block SHALL pulse err and go to IDLE without updating baud_div.
REQ-022 CHECK (one cycle): q = (T+32)>>6, computed without truncation.
REQ-023 CHECK: q==0 SHALL cause err.
REQ-024 CHECK: |T - 4*P1| > T>>3 (inconsistent edges) SHALL cause err.
REQ-025 CHECK: otherwise baud_div SHALL become q-1 and ack SHALL pulse, in the same cycle.
REQ-026 The block SHALL leave CHECK for IDLE unconditionally.
REQ-027 ack and err SHALL never be high together, and each SHALL be high for exactly one cycle per attempt.
REQ-028 Latency: the ack/err pulse SHALL occur exactly 1 clock after the cycle in which the 5th falling edge is detected.
REQ-029 baud_div SHALL hold its value between successful measurements; err SHALL never modify it.
REQ-030 en is sampled only in IDLE and ARMED; en changes during MEASURE or CHECK SHALL be ignored.
REQ-031 busy SHALL be 1 in ARMED, MEASURE and CHECK, and 0 in IDLE.
REQ-032 A falling edge in the same cycle as T overflow SHALL resolve as overflow (err).

Reset
REQ-033 rst_n low SHALL immediately force state to IDLE, and set busy=0, ack=0, err=0, baud_div=DEFAULT_DIV, T=0, P1=0, edge_cnt=0, prescaler=0, and synchronizer flops to 1.
REQ-034 Reset asserted mid-measurement SHALL abort the measurement with no ack or err pulse.
REQ-035 After rst_n rises, the block SHALL return to ARMED only via the IDLE path.

Verification
REQ-036 CLK_FREQ=100, en=1, 0x55 at 9600 baud (T=8333) -> ack, baud_div=129, busy falls 1 cycle after ack.
REQ-037 0x55 at 115200 baud (T=694) -> ack, baud_div=10.
REQ-038 0x55 at 4800 baud -> T overflows at 16383 -> err, baud_div unchanged (129).
REQ-039 0x0F sent at 9600 baud (edge spacing inconsistent) -> err, baud_div unchanged.
REQ-040 rst_n pulsed low after the 3rd falling edge -> busy=0 at once, no ack/err, baud_div=129; a following clean 0x55 at 115200 -> ack, baud_div=10.
REQ-041 en dropped while ARMED before any edge -> IDLE; a later 0x55 produces no ack or err.

Source files
------------

// File: rtl/uart_autobaud.sv
// UART autobaud detector: times the falling edges of a 0x55 sync character
// and converts the span of 8 bit times into a uart_tx/uart_rx divisor.
module uart_autobaud #(
  parameter int CLK_FREQ       = 100,
  parameter int BAUD_DIV_WIDTH = 8,
  parameter int DEFAULT_DIV    = 129
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      rx,
  output logic [BAUD_DIV_WIDTH-1:0] baud_div,
  output logic                      busy,
  output logic                      ack,
  output logic                      err
);

  localparam int CLK_DIV = CLK_FREQ / 10;
  localparam int PW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TW      = BAUD_DIV_WIDTH + 6;
  localparam int DW      = TW + 2;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    MEASURE,
    CHECK
  } state_t;

  state_t                    state_q, state_d;
  logic [2:0]                sync_q, sync_d;
  logic [PW-1:0]             pre_q, pre_d;
  logic [TW-1:0]             t_q, t_d;
  logic [TW-1:0]             p1_q, p1_d;
  logic [2:0]                ecnt_q, ecnt_d;
  logic [BAUD_DIV_WIDTH-1:0] div_q, div_d;
  logic                      busy_q, busy_d;
  logic                      ack_q, ack_d;
  logic                      err_q, err_d;

  logic          fall;
  logic          tick;
  logic          t_max;
  logic [TW:0]   q;
  logic [DW-1:0] t_ext;
  logic [DW-1:0] p1x4;
  logic [DW-1:0] dev;
  logic          bad;

  always_comb begin
    fall  = sync_q[2] & ~sync_q[1];
    tick  = (pre_q == PW'(CLK_DIV - 1));
    t_max = (t_q == '1);
    // rounded T/64, one bit wider than T so T near all-ones cannot wrap
    q     = ({1'b0, t_q} + (TW+1)'(32)) >> 6;
    t_ext = {2'b00, t_q};
    p1x4  = {p1_q, 2'b00};
    dev   = (t_ext >= p1x4) ? t_ext - p1x4 : p1x4 - t_ext;
    bad   = (q == '0) || (dev > {5'b00000, t_q[TW-1:3]});
  end

  always_comb begin
    state_d = state_q;
    sync_d  = {sync_q[1:0], rx};
    pre_d   = tick ? '0 : pre_q + PW'(1);
    t_d     = t_q;
    p1_d    = p1_q;
    ecnt_d  = ecnt_q;
    div_d   = div_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en) state_d = ARMED;
      end
      ARMED: begin
        if (!en) begin
          state_d = IDLE;
        end else if (fall) begin
          state_d = MEASURE;
          t_d     = '0;
          ecnt_d  = '0;
          pre_d   = '0;
        end
      end
      MEASURE: begin
        if (tick && t_max) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          if (tick) t_d = t_q + TW'(1);
          if (fall) begin
            ecnt_d = ecnt_q + 3'd1;
            if (ecnt_q == 3'd0) p1_d = t_q;
            // verdict is registered here so it lands in the CHECK cycle
            if (ecnt_q == 3'd3) begin
              state_d = CHECK;
              t_d     = t_q;
              if (bad) begin
                err_d = 1'b1;
              end else begin
                ack_d = 1'b1;
                div_d = BAUD_DIV_WIDTH'(q - (TW+1)'(1));
              end
            end
          end
        end
      end
      CHECK: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sync_q  <= 3'b111;
      pre_q   <= '0;
      t_q     <= '0;
      p1_q    <= '0;
      ecnt_q  <= '0;
      div_q   <= BAUD_DIV_WIDTH'(DEFAULT_DIV);
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      pre_q   <= pre_d;
      t_q     <= t_d;
      p1_q    <= p1_d;
      ecnt_q  <= ecnt_d;
      div_q   <= div_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  assign baud_div = div_q;
  assign busy     = busy_q;
  assign ack      = ack_q;
  assign err      = err_q;

endmodule

// File: tb/tb_uart_autobaud.sv
// Directed bench for uart_autobaud; 10 MHz clock so one tick per clock.
module tb_uart_autobaud;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] baud_div;
  logic       busy;
  logic       ack;
  logic       err;

  int checks = 0;
  int errors = 0;
  int ack_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;

  localparam logic [9:0] F55 = {1'b1, 8'h55, 1'b0};
  localparam logic [9:0] F0F = {1'b1, 8'h0F, 1'b0};

  always #5 clk = ~clk;

  uart_autobaud #(
    .CLK_FREQ(10),
    .BAUD_DIV_WIDTH(8),
    .DEFAULT_DIV(129)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .rx(rx),
    .baud_div(baud_div),
    .busy(busy),
    .ack(ack),
    .err(err)
  );

  always @(negedge clk) begin
    if (ack) ack_cnt++;
    if (err) err_cnt++;
    if (ack && err) both_cnt++;
  end

  task automatic send_bits(input logic [9:0] fr, input int b,
                           input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      rx = fr[i];
      repeat (b) @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; en = 1'b0; rx = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rst_ack got %b want 0", ack); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", err); end
    checks++; if (baud_div !== 8'd129) begin errors++; $display("FAIL rst_div got %0d want 129", baud_div); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
    en = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL armed_busy got %b want 1", busy); end
  endtask

  task automatic test_fast;
    int a0, e0;
    a0 = ack_cnt; e0 = err_cnt;
    send_bits(F55, 87, 0, 10);
    repeat (4) @(negedge clk); #1;
    checks++; if (ack_cnt !== a0 + 1) begin errors++; $display("FAIL fast_ack got %0d want %0d", ack_cnt, a0 + 1); end
    checks++; if (err_cnt !== e0) begin errors++; $display("FAIL fast_err got %0d want %0d", err_cnt, e0); end
    checks++; if (baud_div !== 8'd10) begin errors++; $display("FAIL fast_div got %0d want 10", baud_div); end
  endtask

  task automatic test_9600_latency;
    send_bits(F55, 1042, 0, 8);
    rx = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL lat_early got %b want 0", ack); end
    @(negedge clk);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL lat_ack got %b want 1", ack); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL lat_err got %b want 0", err); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL lat_busy got %b want 1", busy); end
    checks++; if (baud_div !== 8'd129) begin errors++; $display("FAIL slow_div got %0d want 129", baud_div); end
    @(negedge clk);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL ack_width got %b want 0", ack); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_fall got %b want 0", busy); end
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rearm got %b want 1", busy); end
    repeat (1042 - 5) @(negedge clk);
    rx = 1'b1;
    repeat (1042) @(negedge clk);
  endtask

  task automatic test_overflow;
    int a0, e0;
    a0 = ack_cnt; e0 = err_cnt;
    send_bits(F55, 2083, 0, 8);
    rx = 1'b1;
    repeat (10) @(negedge clk); #1;
    checks++; if (err_cnt !== e0 + 1) begin errors++; $display("FAIL ovf_err got %0d want %0d", err_cnt, e0 + 1); end
    checks++; if (ack_cnt !== a0) begin errors++; $display("FAIL ovf_ack got %0d want %0d", ack_cnt, a0); end
    checks++; if (baud_div !== 8'd129) begin errors++; $display("FAIL ovf_div got %0d want 129", baud_div); end
  endtask

  task automatic test_bad_pattern;
    int a0, e0;
    a0 = ack_cnt; e0 = err_cnt;
    send_bits(F0F, 1042, 0, 10);
    for (int i = 0; i < 8000; i++) begin
      @(negedge clk); #1;
      if (err_cnt != e0) break;
    end
    repeat (2) @(negedge clk); #1;
    checks++; if (err_cnt !== e0 + 1) begin errors++; $display("FAIL bad_err got %0d want %0d", err_cnt, e0 + 1); end
    checks++; if (ack_cnt !== a0) begin errors++; $display("FAIL bad_ack got %0d want %0d", ack_cnt, a0); end
    checks++; if (baud_div !== 8'd129) begin errors++; $display("FAIL bad_div got %0d want 129", baud_div); end
  endtask

  task automatic test_en_ignored;
    int a0;
    a0 = ack_cnt;
    send_bits(F55, 87, 0, 3);
    en = 1'b0;
    send_bits(F55, 87, 3, 10);
    repeat (4) @(negedge clk); #1;
    checks++; if (ack_cnt !== a0 + 1) begin errors++; $display("FAIL enign_ack got %0d want %0d", ack_cnt, a0 + 1); end
    checks++; if (baud_div !== 8'd10) begin errors++; $display("FAIL enign_div got %0d want 10", baud_div); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL enign_idle got %b want 0", busy); end
    en = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int a0, e0;
    a0 = ack_cnt; e0 = err_cnt;
    send_bits(F55, 87, 0, 5);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b want 0", busy); end
    checks++; if (baud_div !== 8'd129) begin errors++; $display("FAIL mid_div got %0d want 129", baud_div); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rel got %b want 0", busy); end
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_rearm got %b want 1", busy); end
    checks++; if (ack_cnt !== a0 || err_cnt !== e0) begin errors++; $display("FAIL mid_pulse got %0d/%0d want %0d/%0d", ack_cnt, err_cnt, a0, e0); end
    send_bits(F55, 87, 0, 10);
    repeat (4) @(negedge clk); #1;
    checks++; if (ack_cnt !== a0 + 1) begin errors++; $display("FAIL post_ack got %0d want %0d", ack_cnt, a0 + 1); end
    checks++; if (baud_div !== 8'd10) begin errors++; $display("FAIL post_div got %0d want 10", baud_div); end
  endtask

  task automatic test_en_drop;
    int a0, e0;
    a0 = ack_cnt; e0 = err_cnt;
    en = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_busy got %b want 0", busy); end
    send_bits(F55, 87, 0, 10);
    repeat (5) @(negedge clk); #1;
    checks++; if (ack_cnt !== a0) begin errors++; $display("FAIL drop_ack got %0d want %0d", ack_cnt, a0); end
    checks++; if (err_cnt !== e0) begin errors++; $display("FAIL drop_err got %0d want %0d", err_cnt, e0); end
    checks++; if (baud_div !== 8'd10) begin errors++; $display("FAIL drop_div got %0d want 10", baud_div); end
  endtask

  initial begin
    test_reset;
    test_fast;
    test_9600_latency;
    test_overflow;
    test_bad_pattern;
    test_en_ignored;
    test_reset_mid;
    test_en_drop;
    checks++; if (both_cnt !== 0) begin errors++; $display("FAIL ack_err_overlap got %0d want 0", both_cnt); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
